dragon_hit_detect: RTL and testbench
====================================

// Module: dragon_hit_detect
// PURPOSE
// - Upstream stage of the dragon movement block: produces its shotDragonCollision[2:0] input.
// - Latches pixel-level overlap between the dragon and each of 3 player shots over one frame.
// - At startOfFrame, reports the hits as a one-cycle pulse vector, then holds off for a cooldown.
// - Keeps a saturating hit count and emits a score pulse for the score stage.
// PARAMETERS
// - NUM_SHOTS       3    number of shot objects (width of shot vectors)
// - COOLDOWN_FRAMES 30   frames after a report during which overlaps are ignored
// - MULTI_HIT       0    0: report lowest-index hit shot only; 1: report all hit shots
// - SCORE_PER_HIT   10   value placed on scoreValue per reported shot
// PORTS
// - clk                 in   1          pixel clock
// - resetN              in   1          async active-low reset
// - startOfFrame        in   1          one-cycle frame strobe
// - pause               in   1          game paused
// - dragonDrawReq       in   1          dragon pixel opaque at current pixel
// - shotDrawReq         in   NUM_SHOTS  shot i pixel opaque at current pixel
// - shotDragonCollision out  NUM_SHOTS  one-cycle hit pulse per shot (to dragon + shot movers)
// - scorePulse          out  1          one-cycle, coincident with a nonzero collision pulse
// - scoreValue          out  8          SCORE_PER_HIT * popcount(reported), valid with scorePulse
// - hitCount            out  8          total reported hits, saturates at 255
// - coolingDown         out  1          high while state is COOLDOWN
// BEHAVIOUR
// - Reset: all outputs 0, pending=0, state ARMED, cooldown counter 0.
// - pending[i] (sticky): set on any cycle with dragonDrawReq && shotDrawReq[i] && state==ARMED && !pause.
// - An overlap in the startOfFrame cycle belongs to the new frame (set after the clear).
// - FSM on startOfFrame (other cycles: only pending updates):
// -   ARMED: pause -> discard pending, stay. pending!=0 -> capture to hitReg, clear pending, go REPORT.
// -          pending==0 -> stay.
// -   REPORT: lasts exactly one cycle (the cycle after startOfFrame); not sof-gated.
// -           shotDragonCollision=hitReg, scorePulse=1, hitCount+=popcount (saturating), cnt=COOLDOWN_FRAMES-1
// -           -> COOLDOWN (or ARMED if COOLDOWN_FRAMES==0).
// -   COOLDOWN: on each sof with !pause, cnt==0 -> ARMED else cnt-=1; paused sof freezes cnt.
// -             overlaps ignored; pending held at 0.
// - Latency: overlap pixel -> pulse = next startOfFrame + 1 cycle.
// - MULTI_HIT=0: hitReg = lowest set bit of pending only; other bits dropped, not deferred.
// - Width: scoreValue computed 10-bit, clipped to 255; hitCount add clips at 255, no wrap.
// - Outputs registered; shotDragonCollision/scorePulse never high outside REPORT.
// - Reset mid-REPORT/COOLDOWN: immediate return to reset values; no pulse emitted.
// STRUCTURE
// - dragon_pkg: NUM_SHOTS_DEF=3, typedef enum logic[1:0] {ARMED,REPORT,COOLDOWN} hit_state_t,
//   function popcount_shots(), SCORE_W=8.
// - One sub-module: sat_counter (WIDTH, MAX; inc amount input, clip at MAX) for hitCount.
// - Rest (pending latch, FSM, cooldown counter, priority pick) in this module.
// TESTING
// - T1 overlap shot1 at 5 pixels mid-frame, next sof -> collision=3'b010 one cycle after sof,
//   scorePulse=1, scoreValue=10, hitCount=1, coolingDown=1.
// - T2 MULTI_HIT=0, shots 0 and 2 overlap same frame -> collision=3'b001 only; MULTI_HIT=1 ->
//   3'b101, scoreValue=20, hitCount+=2.
// - T3 COOLDOWN_FRAMES=3: overlap each frame after a report -> no pulse for 3 sofs; 4th-frame
//   overlap reported at following sof.
// - T4 pause high across overlap and sof -> no pulse, pending discarded; pause during COOLDOWN
//   -> frame count frozen.
// - T5 force 260 reports (COOLDOWN_FRAMES=0, MULTI_HIT=1, 3 shots) -> hitCount stops at 255.
// - T6 resetN low in REPORT cycle and mid-COOLDOWN -> all outputs 0 same cycle, ARMED after release.

Source files
------------

// File: rtl/dragon_pkg.sv
// Shared types and helpers for the dragon hit detector: FSM state encoding,
// output widths and a shot popcount used for scoring and the hit counter.
package dragon_pkg;

    localparam int NUM_SHOTS_DEF = 3;
    localparam int SCORE_W       = 8;
    localparam int MAX_SHOTS     = 8;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        REPORT   = 2'd1,
        COOLDOWN = 2'd2
    } hit_state_t;

    // Callers zero-extend their shot vector to MAX_SHOTS bits.
    function automatic logic [3:0] popcount_shots(input logic [MAX_SHOTS-1:0] shots);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            n = n + {3'b000, shots[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dragon_hit_detect_if.sv
// Frame/pixel inputs and hit-report outputs of the dragon hit detector.
// master drives the pixel stream, slave is the detector.
interface dragon_hit_detect_if
    import dragon_pkg::*;
#(
    parameter int NUM_SHOTS = NUM_SHOTS_DEF
);

    logic                 startOfFrame;
    logic                 pause;
    logic                 dragonDrawReq;
    logic [NUM_SHOTS-1:0] shotDrawReq;
    logic [NUM_SHOTS-1:0] shotDragonCollision;
    logic                 scorePulse;
    logic [SCORE_W-1:0]   scoreValue;
    logic [SCORE_W-1:0]   hitCount;
    logic                 coolingDown;

    modport master (
        output startOfFrame, pause, dragonDrawReq, shotDrawReq,
        input  shotDragonCollision, scorePulse, scoreValue, hitCount, coolingDown
    );

    modport slave (
        input  startOfFrame, pause, dragonDrawReq, shotDrawReq,
        output shotDragonCollision, scorePulse, scoreValue, hitCount, coolingDown
    );

endinterface

// File: rtl/dragon_hit_detect_sat_counter.sv
// Accumulating counter that adds a variable increment and clips at MAX
// instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255,
    parameter int INC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam int SUM_W = ((WIDTH > INC_W) ? WIDTH : INC_W) + 1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        sum     = SUM_W'(count_q) + SUM_W'(inc_i);
        if (inc_en_i) begin
            count_d = (sum > SUM_W'(MAX)) ? WIDTH'(MAX) : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use <= so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dragon_hit_detect.sv
// Latches dragon/shot pixel overlaps across a frame, reports them as a one-cycle
// pulse after startOfFrame, then ignores overlaps for a frame-counted cooldown.
module dragon_hit_detect
    import dragon_pkg::*;
#(
    parameter int NUM_SHOTS       = NUM_SHOTS_DEF,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int MULTI_HIT       = 0,
    parameter int SCORE_PER_HIT   = 10
) (
    input  logic                clk,
    input  logic                resetN,
    dragon_hit_detect_if.slave  bus
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((COOLDOWN_FRAMES > 0) ? (COOLDOWN_FRAMES - 1) : 0);
    localparam hit_state_t AFTER_REPORT = (COOLDOWN_FRAMES > 0) ? COOLDOWN : ARMED;

    hit_state_t           state_q;
    logic [NUM_SHOTS-1:0] pending_q;
    logic [NUM_SHOTS-1:0] pending_d;
    logic [NUM_SHOTS-1:0] collision_q;
    logic [NUM_SHOTS-1:0] hit_d;
    logic [NUM_SHOTS-1:0] overlap;
    logic                 score_pulse_q;
    logic [SCORE_W-1:0]   score_value_q;
    logic [SCORE_W-1:0]   score_d;
    logic [9:0]           score_full;
    logic [3:0]           hit_cnt;
    logic                 cooling_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sof_run;

    assign sof_run = bus.startOfFrame && !bus.pause;
    assign overlap = bus.shotDrawReq &
                     {NUM_SHOTS{bus.dragonDrawReq && (state_q == ARMED) && !bus.pause}};

    // Single-hit mode keeps only the lowest-index shot; the rest are dropped.
    assign hit_d      = (MULTI_HIT != 0) ? pending_q : (pending_q & (-pending_q));
    assign hit_cnt    = popcount_shots(MAX_SHOTS'(hit_d));
    assign score_full = 10'(SCORE_PER_HIT) * 10'(hit_cnt);
    assign score_d    = (score_full > 10'd255) ? 8'hFF : score_full[7:0];

    // A startOfFrame in ARMED closes the frame: the old pending is consumed or
    // discarded, and an overlap on that same cycle starts the new frame.
    always_comb begin
        pending_d = pending_q | overlap;
        if (state_q == COOLDOWN) begin
            pending_d = '0;
        end else if (bus.startOfFrame && (state_q == ARMED)) begin
            pending_d = overlap;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ARMED;
            pending_q     <= '0;
            collision_q   <= '0;
            score_pulse_q <= 1'b0;
            score_value_q <= '0;
            cooling_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            pending_q     <= pending_d;
            collision_q   <= '0;
            score_pulse_q <= 1'b0;
            score_value_q <= '0;
            case (state_q)
                ARMED: begin
                    if (sof_run && (pending_q != '0)) begin
                        state_q       <= REPORT;
                        collision_q   <= hit_d;
                        score_pulse_q <= 1'b1;
                        score_value_q <= score_d;
                    end
                end
                REPORT: begin
                    state_q   <= AFTER_REPORT;
                    cnt_q     <= CNT_INIT;
                    cooling_q <= (AFTER_REPORT == COOLDOWN);
                end
                COOLDOWN: begin
                    if (sof_run) begin
                        if (cnt_q == '0) begin
                            state_q   <= ARMED;
                            cooling_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= ARMED;
                    cooling_q <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (SCORE_W),
        .MAX   (255),
        .INC_W (4)
    ) u_hit_count (
        .clk      (clk),
        .rst_n    (resetN),
        .inc_en_i (state_q == REPORT),
        .inc_i    (popcount_shots(MAX_SHOTS'(collision_q))),
        .count_o  (bus.hitCount)
    );

    assign bus.shotDragonCollision = collision_q;
    assign bus.scorePulse          = score_pulse_q;
    assign bus.scoreValue          = score_value_q;
    assign bus.coolingDown         = cooling_q;

endmodule

// File: tb/tb_dragon_hit_detect.sv
// Directed bench: dut0 (cooldown 3, single-hit) and dut1 (no cooldown, multi-hit)
// with hand-computed collision, score, hit-count and cooldown expectations.
module tb_dragon_hit_detect;

    logic       clk;
    logic [1:0] rst_v;
    logic [1:0] sof_v;
    logic [1:0] pause_v;
    logic [1:0] drag_v;
    logic [2:0] shot_v [2];

    logic [2:0] coll_o  [2];
    logic       pulse_o [2];
    logic [7:0] score_o [2];
    logic [7:0] hits_o  [2];
    logic       cool_o  [2];

    int checks   = 0;
    int failures = 0;

    dragon_hit_detect_if #(.NUM_SHOTS(3)) bus0 ();
    dragon_hit_detect_if #(.NUM_SHOTS(3)) bus1 ();

    assign bus0.startOfFrame  = sof_v[0];
    assign bus0.pause         = pause_v[0];
    assign bus0.dragonDrawReq = drag_v[0];
    assign bus0.shotDrawReq   = shot_v[0];
    assign bus1.startOfFrame  = sof_v[1];
    assign bus1.pause         = pause_v[1];
    assign bus1.dragonDrawReq = drag_v[1];
    assign bus1.shotDrawReq   = shot_v[1];

    assign coll_o[0]  = bus0.shotDragonCollision;
    assign pulse_o[0] = bus0.scorePulse;
    assign score_o[0] = bus0.scoreValue;
    assign hits_o[0]  = bus0.hitCount;
    assign cool_o[0]  = bus0.coolingDown;
    assign coll_o[1]  = bus1.shotDragonCollision;
    assign pulse_o[1] = bus1.scorePulse;
    assign score_o[1] = bus1.scoreValue;
    assign hits_o[1]  = bus1.hitCount;
    assign cool_o[1]  = bus1.coolingDown;

    dragon_hit_detect #(
        .NUM_SHOTS(3), .COOLDOWN_FRAMES(3), .MULTI_HIT(0), .SCORE_PER_HIT(10)
    ) dut0 (
        .clk    (clk),
        .resetN (rst_v[0]),
        .bus    (bus0)
    );

    dragon_hit_detect #(
        .NUM_SHOTS(3), .COOLDOWN_FRAMES(0), .MULTI_HIT(1), .SCORE_PER_HIT(10)
    ) dut1 (
        .clk    (clk),
        .resetN (rst_v[1]),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int coll(input int d);  return int'(coll_o[d]);  endfunction
    function automatic int pulse(input int d); return int'(pulse_o[d]); endfunction
    function automatic int score(input int d); return int'(score_o[d]); endfunction
    function automatic int hits(input int d);  return int'(hits_o[d]);  endfunction
    function automatic int cool(input int d);  return int'(cool_o[d]);  endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int d, input int exp_hits);
        check({tag, "_coll"},  coll(d),  0);
        check({tag, "_pulse"}, pulse(d), 0);
        check({tag, "_score"}, score(d), 0);
        check({tag, "_hits"},  hits(d),  exp_hits);
        check({tag, "_cool"},  cool(d),  0);
    endtask

    // One frame: optional overlap burst, then a startOfFrame cycle. Returns in
    // the cycle right after the sof edge, i.e. the REPORT cycle if one fires.
    task automatic frame(input int d, input logic [2:0] shots, input logic p_frame,
                         input logic p_sof);
        pause_v[d] = p_frame;
        drag_v[d]  = 1'b0;
        shot_v[d]  = 3'b000;
        tick();
        if (shots != 3'b000) begin
            drag_v[d] = 1'b1;
            shot_v[d] = shots;
            repeat (5) tick();
            drag_v[d] = 1'b0;
            shot_v[d] = 3'b000;
        end
        tick();
        check("mid_frame_coll", coll(d), 0);
        pause_v[d] = p_sof;
        sof_v[d]   = 1'b1;
        tick();
        sof_v[d]   = 1'b0;
        pause_v[d] = 1'b0;
    endtask

    task automatic report_check(input string tag, input int d, input int exp_coll,
                                input int exp_score);
        check({tag, "_coll"},  coll(d),  exp_coll);
        check({tag, "_pulse"}, pulse(d), (exp_coll != 0) ? 1 : 0);
        check({tag, "_score"}, score(d), exp_score);
    endtask

    initial begin
        rst_v     = 2'b00;
        sof_v     = 2'b00;
        pause_v   = 2'b00;
        drag_v    = 2'b00;
        shot_v[0] = 3'b000;
        shot_v[1] = 3'b000;
        tick();
        tick();
        check_idle("rst_held0", 0, 0);
        check_idle("rst_held1", 1, 0);
        rst_v = 2'b11;
        tick();
        check_idle("rst_rel0", 0, 0);
        check_idle("rst_rel1", 1, 0);

        // T1: shot1 overlap, reported one cycle after sof
        frame(0, 3'b010, 1'b0, 1'b0);
        report_check("t1", 0, 3'b010, 10);
        check("t1_cool_in_report", cool(0), 0);
        check("t1_hits_in_report", hits(0), 0);
        tick();
        check("t1_coll_after", coll(0), 0);
        check("t1_pulse_after", pulse(0), 0);
        check("t1_hits", hits(0), 1);
        check("t1_cool", cool(0), 1);

        // T3: overlaps ignored for 3 sofs, 4th frame reported
        for (int k = 1; k <= 3; k++) begin
            frame(0, 3'b010, 1'b0, 1'b0);
            check("t3_no_pulse", pulse(0), 0);
            check("t3_cool", cool(0), (k < 3) ? 1 : 0);
        end
        frame(0, 3'b100, 1'b0, 1'b0);
        report_check("t3_4th", 0, 3'b100, 10);
        tick();
        check("t3_hits", hits(0), 2);
        check("t3_cool_again", cool(0), 1);

        // T4b: paused sofs freeze the cooldown frame count
        for (int k = 0; k < 2; k++) begin
            frame(0, 3'b000, 1'b1, 1'b1);
            check("t4_paused_cool", cool(0), 1);
        end
        for (int k = 0; k < 2; k++) begin
            frame(0, 3'b000, 1'b0, 1'b0);
            check("t4_frozen_cool", cool(0), 1);
        end
        frame(0, 3'b000, 1'b0, 1'b0);
        check("t4_cool_done", cool(0), 0);

        // T2a: single-hit mode picks the lowest-index shot
        frame(0, 3'b101, 1'b0, 1'b0);
        report_check("t2a", 0, 3'b001, 10);
        tick();
        check("t2a_hits", hits(0), 3);
        for (int k = 0; k < 3; k++) frame(0, 3'b000, 1'b0, 1'b0);
        check("t2a_armed", cool(0), 0);
        frame(0, 3'b000, 1'b0, 1'b0);
        report_check("t2a_not_deferred", 0, 0, 0);

        // T4a: pause across overlap and sof, then pause only at sof
        frame(0, 3'b010, 1'b1, 1'b1);
        report_check("t4_paused_frame", 0, 0, 0);
        frame(0, 3'b010, 1'b0, 1'b1);
        report_check("t4_paused_sof", 0, 0, 0);
        frame(0, 3'b000, 1'b0, 1'b0);
        report_check("t4_discarded", 0, 0, 0);
        check("t4_hits", hits(0), 3);
        check("t4_cool", cool(0), 0);

        // T6: reset in the REPORT cycle, then mid-COOLDOWN
        frame(0, 3'b001, 1'b0, 1'b0);
        report_check("t6_pre", 0, 3'b001, 10);
        rst_v[0] = 1'b0;
        #1;
        check_idle("t6_rst_report", 0, 0);
        tick();
        rst_v[0] = 1'b1;
        tick();
        check_idle("t6_after_rel", 0, 0);
        frame(0, 3'b010, 1'b0, 1'b0);
        report_check("t6_armed", 0, 3'b010, 10);
        tick();
        check("t6_hits", hits(0), 1);
        check("t6_cool", cool(0), 1);
        frame(0, 3'b000, 1'b0, 1'b0);
        check("t6_mid_cool", cool(0), 1);
        rst_v[0] = 1'b0;
        #1;
        check_idle("t6_rst_cool", 0, 0);
        tick();
        rst_v[0] = 1'b1;
        tick();
        frame(0, 3'b100, 1'b0, 1'b0);
        report_check("t6_armed2", 0, 3'b100, 10);
        tick();
        check("t6_hits2", hits(0), 1);

        // T2b: multi-hit reports both shots
        frame(1, 3'b101, 1'b0, 1'b0);
        report_check("t2b", 1, 3'b101, 20);
        tick();
        check("t2b_hits", hits(1), 2);
        check("t2b_cool", cool(1), 0);

        // T5: three hits per report with no cooldown, hitCount saturates
        for (int k = 1; k <= 100; k++) begin
            drag_v[1] = 1'b1;
            shot_v[1] = 3'b111;
            tick();
            drag_v[1] = 1'b0;
            shot_v[1] = 3'b000;
            sof_v[1]  = 1'b1;
            tick();
            sof_v[1]  = 1'b0;
            if (k == 1) report_check("t5_first", 1, 3'b111, 30);
            tick();
            if (k == 84) check("t5_hits_254", hits(1), 254);
        end
        check("t5_hits_sat", hits(1), 255);
        check("t5_coll_idle", coll(1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
